// File: rtl/ook_byte_encoder.sv
// ----------------------------------------------------------------------------
// ook_byte_encoder
//
// Last stage of the UART-to-433 MHz path. Bytes from the UART receiver are
// buffered in a small FIFO and each one is sent as an on-off-keyed,
// pulse-width-coded frame (EV1527 style): a sync pulse, then 8 data bits
// MSB first. The frame is repeated REPEATS times per byte.
//
// Frame timing in units (1 unit = UNIT_CYCLES clocks):
//   sync : high 1, low SYNC_UNITS
//   bit 1: high 3, low 1
//   bit 0: high 1, low 3
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   in_data   byte from the UART receiver
//   in_valid  in_data is valid
//   in_ready  FIFO can accept; a byte transfers when in_valid & in_ready
//   rf_tx     registered OOK output to the transmitter and LED (1 = carrier)
//   busy      high while a frame is being emitted
// ----------------------------------------------------------------------------
module ook_byte_encoder #(
  parameter int CLK_HZ     = 12000000,
  parameter int UNIT_US    = 350,
  parameter int SYNC_UNITS = 31,
  parameter int REPEATS    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       rf_tx,
  output logic       busy
);

  localparam int UNIT_CYCLES = CLK_HZ / 1000000 * UNIT_US;
  localparam int TW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int UW = $clog2((SYNC_UNITS > 3) ? SYNC_UNITS : 3);
  localparam int RW = (REPEATS > 1) ? $clog2(REPEATS) : 1;

  localparam logic [TW-1:0] UNIT_LAST = TW'(UNIT_CYCLES - 1);
  localparam logic [UW-1:0] SYNC_LAST = UW'(SYNC_UNITS - 1);
  localparam logic [UW-1:0] LONG_LAST = UW'(2);
  localparam logic [UW-1:0] ONE_LAST  = '0;
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEATS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  // Parameter sanity checks, evaluated at elaboration
  if (UNIT_CYCLES < 2) begin : g_bad_unit
    $error("ook_byte_encoder: UNIT_CYCLES must be at least 2");
  end
  if (REPEATS < 1) begin : g_bad_repeats
    $error("ook_byte_encoder: REPEATS must be at least 1");
  end
  if (SYNC_UNITS < 1) begin : g_bad_sync
    $error("ook_byte_encoder: SYNC_UNITS must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ook_byte_encoder: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    SYNC_HI,
    SYNC_LO,
    BIT_HI,
    BIT_LO
  } state_t;

  state_t          state;
  logic [TW-1:0]   unit_cnt;
  logic [UW-1:0]   units_left;
  logic [2:0]      bit_idx;
  logic [RW-1:0]   rep;
  logic [7:0]      shreg;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            push;
  logic            pop;
  logic            phase_done;
  logic            frame_done;
  logic            fifo_nonempty;

  // A phase ends on the last clock of its last unit; both counters are
  // reloaded on the same edge the next phase starts, so no clock is lost.
  assign phase_done    = (unit_cnt == '0) && (units_left == '0);
  assign frame_done    = (state == BIT_LO) && phase_done &&
                         (bit_idx == 3'd0) && (rep == REP_LAST);
  assign fifo_nonempty = (count != '0);
  assign in_ready      = (count != FULL_CNT);
  assign push          = in_valid && in_ready;
  assign pop           = fifo_nonempty && ((state == IDLE) || frame_done);

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer. The unit timer free-runs inside a phase; every phase
  // transition below reloads it, overriding the default countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rf_tx      <= 1'b0;
      busy       <= 1'b0;
      unit_cnt   <= '0;
      units_left <= '0;
      bit_idx    <= 3'd0;
      rep        <= '0;
      shreg      <= 8'h00;
    end else begin
      if (state != IDLE && !phase_done) begin
        if (unit_cnt == '0) begin
          unit_cnt   <= UNIT_LAST;
          units_left <= units_left - UW'(1);
        end else begin
          unit_cnt <= unit_cnt - TW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (pop) begin
            shreg      <= mem[rd_ptr];
            rep        <= '0;
            bit_idx    <= 3'd7;
            state      <= SYNC_HI;
            rf_tx      <= 1'b1;
            busy       <= 1'b1;
            unit_cnt   <= UNIT_LAST;
            units_left <= ONE_LAST;
          end
        end

        SYNC_HI: begin
          if (phase_done) begin
            state      <= SYNC_LO;
            rf_tx      <= 1'b0;
            unit_cnt   <= UNIT_LAST;
            units_left <= SYNC_LAST;
          end
        end

        SYNC_LO: begin
          if (phase_done) begin
            state      <= BIT_HI;
            rf_tx      <= 1'b1;
            unit_cnt   <= UNIT_LAST;
            units_left <= shreg[bit_idx] ? LONG_LAST : ONE_LAST;
          end
        end

        BIT_HI: begin
          if (phase_done) begin
            state      <= BIT_LO;
            rf_tx      <= 1'b0;
            unit_cnt   <= UNIT_LAST;
            units_left <= shreg[bit_idx] ? ONE_LAST : LONG_LAST;
          end
        end

        BIT_LO: begin
          if (phase_done) begin
            unit_cnt <= UNIT_LAST;
            if (bit_idx != 3'd0) begin
              bit_idx    <= bit_idx - 3'd1;
              state      <= BIT_HI;
              rf_tx      <= 1'b1;
              units_left <= shreg[bit_idx - 3'd1] ? LONG_LAST : ONE_LAST;
            end else if (rep != REP_LAST) begin
              rep        <= rep + RW'(1);
              bit_idx    <= 3'd7;
              state      <= SYNC_HI;
              rf_tx      <= 1'b1;
              units_left <= ONE_LAST;
            end else if (pop) begin
              // Next byte starts straight away, no idle gap
              shreg      <= mem[rd_ptr];
              rep        <= '0;
              bit_idx    <= 3'd7;
              state      <= SYNC_HI;
              rf_tx      <= 1'b1;
              units_left <= ONE_LAST;
            end else begin
              state      <= IDLE;
              rf_tx      <= 1'b0;
              busy       <= 1'b0;
              unit_cnt   <= '0;
              units_left <= '0;
            end
          end
        end

        default: begin
          state <= IDLE;
          rf_tx <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ook_byte_encoder.sv
// ----------------------------------------------------------------------------
// tb_ook_byte_encoder
//
// Directed bench for ook_byte_encoder with a 4-clock unit, 2 repeats and a
// 4-deep FIFO. rf_tx is captured cycle by cycle and compared to a waveform
// built from the protocol description, plus hand-computed pulse lengths.
// ----------------------------------------------------------------------------
module tb_ook_byte_encoder;

  localparam int UNIT       = 4;
  localparam int SYNC_UNITS = 31;
  localparam int REPEATS    = 2;
  localparam int BYTE_CYC   = 512;
  localparam int TAIL       = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       rf_tx;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_hi = 0;

  logic cap_rf [0:4095];
  logic exp_rf [0:4095];

  typedef struct {
    logic [7:0] data;
    int         exp_first_hi;
    int         exp_last_hi;
    int         exp_frame_hi;
    int         exp_busy;
  } vec_t;

  vec_t vecs [5];

  ook_byte_encoder #(
    .CLK_HZ    (1000000),
    .UNIT_US   (4),
    .SYNC_UNITS(SYNC_UNITS),
    .REPEATS   (REPEATS),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .rf_tx   (rf_tx),
    .busy    (busy)
  );

  // 10-time-unit clock
  always #5 clk = ~clk;

  // Free-running cycle counter used to time handshake accepts
  always @(posedge clk) cyc <= cyc + 1;

  // Global watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and reports actual vs required on a miss
  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Push one byte; returns #1 after the accepting edge with in_valid low
  task automatic applyStimulus(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sample rf_tx/busy once per cycle, starting at the current time
  task automatic capture(input int n);
    busy_hi = 0;
    for (int i = 0; i < n; i++) begin
      cap_rf[i] = rf_tx;
      if (busy === 1'b1) busy_hi++;
      @(posedge clk);
      #1;
    end
  endtask

  // Expected waveform for one byte, written from index base; returns end index
  function automatic int model_byte(input logic [7:0] b, input int base);
    int idx = base;
    for (int r = 0; r < REPEATS; r++) begin
      for (int c = 0; c < UNIT; c++) exp_rf[idx++] = 1'b1;
      for (int c = 0; c < SYNC_UNITS * UNIT; c++) exp_rf[idx++] = 1'b0;
      for (int k = 7; k >= 0; k--) begin
        int hi_u = b[k] ? 3 : 1;
        int lo_u = b[k] ? 1 : 3;
        for (int c = 0; c < hi_u * UNIT; c++) exp_rf[idx++] = 1'b1;
        for (int c = 0; c < lo_u * UNIT; c++) exp_rf[idx++] = 1'b0;
      end
    end
    return idx;
  endfunction

  function automatic void model_idle(input int from, input int to);
    for (int i = from; i < to; i++) exp_rf[i] = 1'b0;
  endfunction

  function automatic int run_len(input int start, input logic val, input int limit);
    int n = 0;
    while (start + n < limit && cap_rf[start + n] === val) n++;
    return n;
  endfunction

  function automatic int count_hi(input int start, input int len);
    int n = 0;
    for (int i = start; i < start + len; i++) if (cap_rf[i] === 1'b1) n++;
    return n;
  endfunction

  // Whole-waveform comparison, reported as a single comparison
  task automatic compareWave(input string name, input int n);
    int first = -1;
    for (int i = 0; i < n; i++) begin
      if (first < 0 && cap_rf[i] !== exp_rf[i]) first = i;
    end
    vectors++;
    if (first >= 0) begin
      miscompares++;
      $display("[TB] FAIL %s: rf_tx at cycle %0d got %0b, expected %0b",
               name, first, cap_rf[first], exp_rf[first]);
    end
  endtask

  // Two bytes pushed on consecutive edges; the second push lands on the pop
  task automatic twoByteCase(input string name, input logic [7:0] b0, input logic [7:0] b1,
                             input int exp_gap_lo);
    int n;
    applyStimulus(b0);
    applyStimulus(b1);
    checkOutput({name, "_ready_after_pushes"}, in_ready, 1);
    capture(2 * BYTE_CYC + TAIL);
    n = model_byte(b0, 0);
    n = model_byte(b1, n);
    model_idle(n, 2 * BYTE_CYC + TAIL);
    compareWave({name, "_wave"}, 2 * BYTE_CYC + TAIL);
    checkOutput({name, "_busy_cycles"}, busy_hi, 1024);
    checkOutput({name, "_last_lo_len"}, run_len(BYTE_CYC - exp_gap_lo, 1'b0, 4096), exp_gap_lo);
    checkOutput({name, "_second_sync_hi"}, run_len(BYTE_CYC, 1'b1, 4096), 4);
  endtask

  logic [7:0] full_bytes [6];
  int         acc [6];

  initial begin
    int n;
    int wait_n;

    vecs[0] = '{8'hA5, 12, 12,  68, 512};
    vecs[1] = '{8'h00,  4,  4,  36, 512};
    vecs[2] = '{8'hFF, 12, 12, 100, 512};
    vecs[3] = '{8'h3C,  4,  4,  68, 512};
    vecs[4] = '{8'h81, 12, 12,  52, 512};

    full_bytes = '{8'h11, 8'hE7, 8'h42, 8'h99, 8'h3C, 8'hD2};

    // Reset held for 3 clocks, then quiet idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("reset_rf_tx", rf_tx, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    capture(1000);
    checkOutput("idle_rf_tx_high_cycles", count_hi(0, 1000), 0);
    checkOutput("idle_busy_cycles", busy_hi, 0);

    // Single-byte table
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].data);
      @(posedge clk);
      #1;
      capture(BYTE_CYC + TAIL);
      n = model_byte(vecs[v].data, 0);
      model_idle(n, BYTE_CYC + TAIL);
      compareWave($sformatf("vec%0d_wave", v), BYTE_CYC + TAIL);
      checkOutput($sformatf("vec%0d_sync_hi", v), run_len(0, 1'b1, 4096), 4);
      checkOutput($sformatf("vec%0d_sync_lo", v), run_len(4, 1'b0, 4096), 124);
      checkOutput($sformatf("vec%0d_first_bit_hi", v), run_len(128, 1'b1, 4096), vecs[v].exp_first_hi);
      checkOutput($sformatf("vec%0d_last_bit_hi", v), run_len(240, 1'b1, 4096), vecs[v].exp_last_hi);
      checkOutput($sformatf("vec%0d_frame0_hi", v), count_hi(0, 256), vecs[v].exp_frame_hi);
      checkOutput($sformatf("vec%0d_frame1_hi", v), count_hi(256, 256), vecs[v].exp_frame_hi);
      checkOutput($sformatf("vec%0d_busy_cycles", v), busy_hi, vecs[v].exp_busy);
    end

    // Back-to-back bytes, and a push coinciding with the IDLE pop
    twoByteCase("b2b", 8'hFF, 8'h00, 4);
    twoByteCase("simul", 8'h5A, 8'hC3, 4);

    // FIFO full: in_valid held high for six bytes
    in_data  = full_bytes[0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc[0] = cyc;
    fork
      begin
        for (int i = 1; i < 6; i++) begin
          in_data = full_bytes[i];
          wait_n = 0;
          while (!in_ready && wait_n < 2000) begin
            @(posedge clk);
            #1;
            wait_n++;
          end
          if (!in_ready) begin
            checkOutput($sformatf("full_accept%0d_timeout", i), 0, 1);
            acc[i] = -1;
          end else begin
            @(posedge clk);
            #1;
            acc[i] = cyc;
            if (i == 4) checkOutput("full_ready_after_5th", in_ready, 0);
          end
        end
        in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        #1;
        capture(6 * BYTE_CYC + TAIL);
      end
    join
    checkOutput("full_5th_accept_delay", acc[4] - acc[0], 4);
    checkOutput("full_6th_accept_delay", acc[5] - acc[0], 514);
    n = 0;
    for (int i = 0; i < 6; i++) n = model_byte(full_bytes[i], n);
    model_idle(n, 6 * BYTE_CYC + TAIL);
    compareWave("full_wave", 6 * BYTE_CYC + TAIL);
    checkOutput("full_busy_cycles", busy_hi, 6 * BYTE_CYC);

    // Reset during BIT_HI of the second queued byte
    applyStimulus(8'h0F);
    applyStimulus(8'hF0);
    repeat (BYTE_CYC + 128 + 2) @(posedge clk);
    #1;
    checkOutput("midrst_pre_rf_tx", rf_tx, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rf_tx", rf_tx, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    capture(600);
    checkOutput("postrst_rf_tx_high_cycles", count_hi(0, 600), 0);
    checkOutput("postrst_busy_cycles", busy_hi, 0);
    applyStimulus(8'h5A);
    @(posedge clk);
    #1;
    capture(BYTE_CYC + TAIL);
    n = model_byte(8'h5A, 0);
    model_idle(n, BYTE_CYC + TAIL);
    compareWave("postrst_wave", BYTE_CYC + TAIL);
    checkOutput("postrst_busy_one_byte", busy_hi, BYTE_CYC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
